// File: rtl/cfg_frame_decoder_pkg.sv
// Shared types and constants for the UART configuration-frame decoder.
// Holds the state encoding, error codes, bus payload and checksum helper.
package cfg_frame_decoder_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DHI_W  = 6;
   localparam int unsigned DATA_W = DHI_W + BYTE_W;
   localparam int unsigned ERR_W  = 4;
   localparam int unsigned CNT_OUT_W = 8;

   localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

   localparam logic [ERR_W-1:0] ERR_ADDR    = 4'h1;
   localparam logic [ERR_W-1:0] ERR_DATA    = 4'h2;
   localparam logic [ERR_W-1:0] ERR_CSUM    = 4'h3;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT = 4'h4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_DHI      = 3'd2,
      ST_DLO      = 3'd3,
      ST_CSUM     = 3'd4,
      ST_ISSUE    = 3'd5,
      ST_WAIT_RDY = 3'd6
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cfg_wr_t;

   // Checksum of the three payload bytes; the latched fields carry only the legal bits.
   function automatic logic [BYTE_W-1:0] frame_csum(
      input logic [ADDR_W-1:0] addr,
      input logic [DHI_W-1:0]  dhi,
      input logic [BYTE_W-1:0] dlo
   );
      return {4'h0, addr} ^ {2'b00, dhi} ^ dlo;
   endfunction

endpackage

// File: rtl/cfg_timeout_cnt.sv
// Inter-byte idle counter: clears on clr, counts while en, flags the last allowed cycle.
module cfg_timeout_cnt #(
   parameter int unsigned LIMIT = 100000,
   parameter int unsigned W     = 17
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit_c
);

   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Saturates at LAST so a stalled enable never wraps into a false gap.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_c = en & (cnt_q == LAST);

endmodule

// File: rtl/cfg_frame_decoder.sv
// Parses 5-byte UART frames (HEADER, ADDR, DHI, DLO, CSUM) into configuration-bus
// writes, reporting malformed frames and inter-byte timeouts as error codes.
module cfg_frame_decoder
   import cfg_frame_decoder_pkg::*;
#(
   parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned CNT_W          = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BYTE_W-1:0]    rx_data,
   input  logic                 rx_empty,
   output logic                 rx_rd,
   output logic                 c_valid,
   output logic [ADDR_W-1:0]    c_addr,
   output logic [DATA_W-1:0]    c_data,
   input  logic                 c_ready,
   output logic [ERR_W-1:0]     err_code,
   output logic                 err_valid,
   output logic                 frame_done,
   output logic [CNT_OUT_W-1:0] frame_count
);

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DHI_W-1:0]       dhi_q, dhi_d;
   logic [BYTE_W-1:0]      dlo_q, dlo_d;
   cfg_wr_t                wr_q, wr_d;
   logic                   c_valid_q, c_valid_d;
   logic [ERR_W-1:0]       err_code_q, err_code_d;
   logic                   err_valid_q, err_valid_d;
   logic                   frame_done_q, frame_done_d;
   logic [CNT_OUT_W-1:0]   frame_count_q, frame_count_d;

   logic in_frame;
   logic pop;
   logic tmo_hit_c;
   logic timeout;

   // Bytes are popped in every parsing state; ISSUE/WAIT_RDY backpressure upstream.
   assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DHI) ||
                     (state_q == ST_DLO)  || (state_q == ST_CSUM);
   assign pop      = ((state_q == ST_IDLE) || in_frame) && !rx_empty;
   assign rx_rd    = pop;
   assign timeout  = tmo_hit_c & rx_empty;

   cfg_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES),
      .W     (CNT_W)
   ) u_tmo (
      .clk   (clk),
      .rst   (rst),
      .clr   (pop || (state_q == ST_IDLE)),
      .en    (in_frame),
      .hit_c (tmo_hit_c)
   );

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      dhi_d         = dhi_q;
      dlo_d         = dlo_q;
      wr_d          = wr_q;
      c_valid_d     = 1'b0;
      err_code_d    = err_code_q;
      err_valid_d   = 1'b0;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;

      case (state_q)
         ST_IDLE: begin
            if (pop && (rx_data == HEADER)) begin
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (pop) begin
               if (rx_data[7:4] != 4'h0) begin
                  err_code_d  = ERR_ADDR;
                  err_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  addr_d  = rx_data[ADDR_W-1:0];
                  state_d = ST_DHI;
               end
            end
         end
         ST_DHI: begin
            if (pop) begin
               if (rx_data[7:6] != 2'b00) begin
                  err_code_d  = ERR_DATA;
                  err_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  dhi_d   = rx_data[DHI_W-1:0];
                  state_d = ST_DLO;
               end
            end
         end
         ST_DLO: begin
            if (pop) begin
               dlo_d   = rx_data;
               state_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (pop) begin
               if (rx_data == frame_csum(addr_q, dhi_q, dlo_q)) begin
                  state_d = ST_ISSUE;
               end else begin
                  err_code_d  = ERR_CSUM;
                  err_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         ST_ISSUE: begin
            c_valid_d = 1'b1;
            wr_d.addr = addr_q;
            wr_d.data = {dhi_q, dlo_q};
            state_d   = ST_WAIT_RDY;
         end
         ST_WAIT_RDY: begin
            // Valid stays up through the acceptance cycle and drops one cycle later.
            c_valid_d = 1'b1;
            if (c_ready) begin
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + CNT_OUT_W'(1);
               state_d       = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Only raised when no byte is available, so it never competes with a pop.
      if (timeout) begin
         err_code_d  = ERR_TIMEOUT;
         err_valid_d = 1'b1;
         state_d     = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         dhi_q         <= '0;
         dlo_q         <= '0;
         wr_q          <= '0;
         c_valid_q     <= 1'b0;
         err_code_q    <= '0;
         err_valid_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         dhi_q         <= dhi_d;
         dlo_q         <= dlo_d;
         wr_q          <= wr_d;
         c_valid_q     <= c_valid_d;
         err_code_q    <= err_code_d;
         err_valid_q   <= err_valid_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign c_valid     = c_valid_q;
   assign c_addr      = wr_q.addr;
   assign c_data      = wr_q.data;
   assign err_code    = err_code_q;
   assign err_valid   = err_valid_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_cfg_frame_decoder.sv
// Self-checking bench for cfg_frame_decoder: directed frame table, hand-written
// timing sequences and a randomized byte stream against a frame-level model.
module tb_cfg_frame_decoder;

   localparam int unsigned TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_empty = 1'b1;
   logic        rx_rd;
   logic        c_valid;
   logic [3:0]  c_addr;
   logic [13:0] c_data;
   logic        c_ready = 1'b0;
   logic [3:0]  err_code;
   logic        err_valid;
   logic        frame_done;
   logic [7:0]  frame_count;

   cfg_frame_decoder #(
      .HEADER         (8'hA5),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_empty    (rx_empty),
      .rx_rd       (rx_rd),
      .c_valid     (c_valid),
      .c_addr      (c_addr),
      .c_data      (c_data),
      .c_ready     (c_ready),
      .err_code    (err_code),
      .err_valid   (err_valid),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   initial forever #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Upstream register: each byte becomes visible 'gap' idle cycles after the previous pop.
   typedef struct { logic [7:0] b; int gap; } src_t;
   src_t srcq[$];
   int   src_wait = 0;
   int   rdy_force = 1;

   // Observations from the most recent cycle.
   logic        s_rd, s_valid, s_errv;
   int          ev_err_n, ev_wr_n;
   logic [3:0]  ev_err_code, ev_addr;
   logic [13:0] ev_data;

   // Frame-level reference model.
   int          m_pos, m_phase, m_gap;
   logic [7:0]  m_frm [1:4];
   logic        m_rd, m_valid, m_errv, m_done;
   logic [3:0]  m_addr, m_errc;
   logic [13:0] m_data;
   logic [7:0]  m_cnt;

   typedef struct {
      logic [63:0] bytes;
      int          len;
      int          exp_err;
      int          exp_wr;
      logic [3:0]  exp_addr;
      logic [13:0] exp_data;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pos = 0; m_phase = 0; m_gap = 0;
      for (int i = 1; i <= 4; i++) m_frm[i] = 8'h00;
      m_rd = 1'b0; m_valid = 1'b0; m_errv = 1'b0; m_done = 1'b0;
      m_addr = 4'h0; m_errc = 4'h0; m_data = 14'h0; m_cnt = 8'h00;
   endtask

   task automatic model_err(input logic [3:0] code);
      m_errv = 1'b1; m_errc = code; m_pos = 0;
   endtask

   // Advance the model by one clock using the inputs presented this cycle.
   task automatic model_step();
      logic [7:0] b;
      b = rx_data;
      m_errv = 1'b0;
      m_done = 1'b0;
      if (m_phase == 0) begin
         m_valid = 1'b0;
         if (m_rd) begin
            m_gap = 0;
            if (m_pos == 0) begin
               if (b == 8'hA5) m_pos = 1;
            end else if (m_pos == 1 && b > 8'h0F) begin
               model_err(4'h1);
            end else if (m_pos == 2 && b > 8'h3F) begin
               model_err(4'h2);
            end else if (m_pos == 4) begin
               if (b == (m_frm[1] ^ m_frm[2] ^ m_frm[3])) begin
                  m_phase = 1; m_pos = 0;
               end else begin
                  model_err(4'h3);
               end
            end else begin
               m_frm[m_pos] = b;
               m_pos++;
            end
         end else if (m_pos > 0) begin
            if (m_gap == int'(TMO) - 1) model_err(4'h4);
            else m_gap++;
         end
      end else if (m_phase == 1) begin
         m_valid = 1'b1;
         m_addr  = m_frm[1][3:0];
         m_data  = m_frm[2] * 14'd256 + 14'(m_frm[3]);
         m_phase = 2;
      end else begin
         m_valid = 1'b1;
         if (c_ready) begin
            m_done  = 1'b1;
            m_cnt   = m_cnt + 8'd1;
            m_phase = 0;
         end
      end
   endtask

   task automatic model_compare();
      m_rd = (m_phase == 0) && !rx_empty;
      check("rx_rd", 32'(rx_rd), 32'(m_rd));
      check("c_valid", 32'(c_valid), 32'(m_valid));
      check("err_valid", 32'(err_valid), 32'(m_errv));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("frame_count", 32'(frame_count), 32'(m_cnt));
      if (m_valid) begin
         check("c_addr", 32'(c_addr), 32'(m_addr));
         check("c_data", 32'(c_data), 32'(m_data));
      end
      if (m_errv) check("err_code", 32'(err_code), 32'(m_errc));
   endtask

   task automatic clear_stats();
      ev_err_n = 0; ev_wr_n = 0; ev_err_code = 4'h0; ev_addr = 4'h0; ev_data = 14'h0;
   endtask

   task automatic push(input logic [7:0] b, input int gap);
      src_t e;
      e.b = b; e.gap = gap;
      if (srcq.size() == 0) src_wait = gap;
      srcq.push_back(e);
   endtask

   task automatic push_frame(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo, input int gap);
      push(8'hA5, gap); push(a, gap); push(hi, gap); push(lo, gap); push(a ^ hi ^ lo, gap);
   endtask

   task automatic run_cycle();
      @(negedge clk);
      if (srcq.size() > 0 && src_wait == 0) begin
         rx_empty = 1'b0; rx_data = srcq[0].b;
      end else begin
         rx_empty = 1'b1; rx_data = 8'($urandom);
         if (srcq.size() > 0) src_wait--;
      end
      c_ready = (rdy_force < 0) ? ($urandom_range(0, 9) < 7) : rdy_force[0];
      #1;
      model_compare();
      s_rd = rx_rd; s_valid = c_valid; s_errv = err_valid;
      if (err_valid) begin ev_err_n++; ev_err_code = err_code; end
      if (frame_done) begin ev_wr_n++; ev_addr = c_addr; ev_data = c_data; end
      model_step();
      if (rx_rd && srcq.size() > 0) begin
         srcq.delete(0);
         src_wait = (srcq.size() > 0) ? srcq[0].gap : 0;
      end
      cyc++;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b0; rx_empty = 1'b1; c_ready = 1'b0;
      srcq.delete(); src_wait = 0;
      #1;
      check({tag, "_rx_rd"}, 32'(rx_rd), 32'd0);
      check({tag, "_c_valid"}, 32'(c_valid), 32'd0);
      check({tag, "_c_addr"}, 32'(c_addr), 32'd0);
      check({tag, "_c_data"}, 32'(c_data), 32'd0);
      check({tag, "_err_code"}, 32'(err_code), 32'd0);
      check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   initial begin
      #900000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      int pops, p, e, rise, hi, viol, first_pop, kind, budget;
      logic [7:0] a, dh, dl;

      vecs[0] = '{64'h00000025341203A5, 5, 0, 1, 4'h3, 14'h1234};
      vecs[1] = '{64'h00000026341203A5, 5, 3, 0, 4'h0, 14'h0000};
      vecs[2] = '{64'h25341203A513FF00, 8, 0, 1, 4'h3, 14'h1234};
      vecs[3] = '{64'h00000000000013A5, 2, 1, 0, 4'h0, 14'h0000};
      vecs[4] = '{64'h00000000005203A5, 3, 2, 0, 4'h0, 14'h0000};
      vecs[5] = '{64'h000000CFFF3F0FA5, 5, 0, 1, 4'hF, 14'h3FFF};
      vecs[6] = '{64'h000000A5A50000A5, 5, 0, 1, 4'h0, 14'h00A5};
      vecs[7] = '{64'h000000000000A5A5, 2, 1, 0, 4'h0, 14'h0000};

      model_reset();
      clear_stats();
      do_reset("reset");

      // Directed frame table with c_ready tied high.
      rdy_force = 1;
      for (int v = 0; v < 8; v++) begin
         logic [63:0] bs;
         clear_stats();
         bs = vecs[v].bytes;
         for (int i = 0; i < vecs[v].len; i++) push(bs[8*i +: 8], 0);
         run_n(20);
         check($sformatf("vec%0d_err_n", v), 32'(ev_err_n), 32'((vecs[v].exp_err != 0) ? 1 : 0));
         if (vecs[v].exp_err != 0) check($sformatf("vec%0d_err_code", v), 32'(ev_err_code), 32'(vecs[v].exp_err));
         check($sformatf("vec%0d_wr_n", v), 32'(ev_wr_n), 32'(vecs[v].exp_wr));
         if (vecs[v].exp_wr != 0) begin
            check($sformatf("vec%0d_addr", v), 32'(ev_addr), 32'(vecs[v].exp_addr));
            check($sformatf("vec%0d_data", v), 32'(ev_data), 32'(vecs[v].exp_data));
         end
      end

      // Latency from CSUM pop to c_valid, and valid width with ready high.
      clear_stats();
      push_frame(8'h03, 8'h12, 8'h34, 0);
      pops = 0; p = -100; rise = -1; hi = 0;
      for (int i = 0; i < 20; i++) begin
         run_cycle();
         if (s_rd) begin pops++; if (pops == 5) p = i; end
         if (s_valid) begin hi++; if (rise < 0) rise = i; end
      end
      check("latency", 32'(rise - p), 32'd2);
      check("valid_width", 32'(hi), 32'd2);

      // Backpressure: ready low with the next frame already waiting.
      clear_stats();
      rdy_force = 0;
      push_frame(8'h03, 8'h12, 8'h34, 0);
      push_frame(8'h05, 8'h01, 8'h02, 0);
      s_valid = 1'b0;
      for (int i = 0; i < 20 && !s_valid; i++) run_cycle();
      check("bp_valid_seen", 32'(s_valid), 32'd1);
      viol = 0;
      for (int i = 0; i < 5; i++) begin
         run_cycle();
         if (s_rd !== 1'b0 || c_valid !== 1'b1 || c_data !== 14'h1234 || c_addr !== 4'h3) viol++;
      end
      check("bp_hold", 32'(viol), 32'd0);
      rdy_force = 1;
      first_pop = -1;
      for (int i = 0; i < 20; i++) begin
         run_cycle();
         if (s_rd && first_pop < 0) first_pop = i;
      end
      check("bp_first_pop", 32'(first_pop), 32'd1);
      check("bp_wr_n", 32'(ev_wr_n), 32'd2);
      check("bp_addr2", 32'(ev_addr), 32'h5);
      check("bp_data2", 32'(ev_data), 32'h0102);

      // Silence after ADDR: timeout error.
      clear_stats();
      push(8'hA5, 0); push(8'h03, 0);
      pops = 0; p = -100; e = -1;
      for (int i = 0; i < 20; i++) begin
         run_cycle();
         if (s_rd) begin pops++; if (pops == 2) p = i; end
         if (s_errv && e < 0) e = i;
      end
      check("tmo_delay", 32'(e - p), 32'd9);
      check("tmo_err_n", 32'(ev_err_n), 32'd1);
      check("tmo_code", 32'(ev_err_code), 32'h4);

      // Byte arriving on the expiry cycle wins; one cycle later loses.
      clear_stats();
      push(8'hA5, 0); push(8'h03, 0); push(8'h12, 7); push(8'h34, 0); push(8'h25, 0);
      run_n(30);
      check("tmo_edge_err_n", 32'(ev_err_n), 32'd0);
      check("tmo_edge_wr_n", 32'(ev_wr_n), 32'd1);
      clear_stats();
      push(8'hA5, 0); push(8'h03, 0); push(8'h12, 8); push(8'h34, 0); push(8'h25, 0);
      run_n(30);
      check("tmo_late_err_n", 32'(ev_err_n), 32'd1);
      check("tmo_late_code", 32'(ev_err_code), 32'h4);
      check("tmo_late_wr_n", 32'(ev_wr_n), 32'd0);

      // Reset mid-frame, then a clean frame.
      push(8'hA5, 0); push(8'h03, 0); push(8'h12, 0);
      run_n(4);
      do_reset("rst_frame");
      clear_stats();
      push_frame(8'h03, 8'h12, 8'h34, 0);
      run_n(20);
      check("post_rst_wr_n", 32'(ev_wr_n), 32'd1);
      check("post_rst_data", 32'(ev_data), 32'h1234);
      check("post_rst_count", 32'(frame_count), 32'd1);

      // Reset mid-handshake drops c_valid at once.
      rdy_force = 0;
      push_frame(8'h07, 8'h2A, 8'h55, 0);
      s_valid = 1'b0;
      for (int i = 0; i < 20 && !s_valid; i++) run_cycle();
      check("hs_valid_seen", 32'(s_valid), 32'd1);
      do_reset("rst_hs");
      rdy_force = 1;
      run_n(5);

      // Randomized stream of good, corrupt, noisy and slow frames.
      rdy_force = -1;
      for (int f = 0; f < 300; f++) begin
         int g;
         kind = int'($urandom_range(0, 9));
         g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 10)) : int'($urandom_range(0, 2));
         a  = 8'($urandom_range(0, 15));
         dh = 8'($urandom_range(0, 63));
         dl = 8'($urandom);
         if (kind <= 5) push_frame(a, dh, dl, g);
         else if (kind == 6) begin
            push(8'hA5, g); push(a, g); push(dh, g); push(dl, g); push(a ^ dh ^ dl ^ 8'h01, g);
         end else if (kind == 7) push(8'($urandom), g);
         else if (kind == 8) begin
            push(8'hA5, g);
            for (int i = 0; i < 4; i++) push(8'($urandom), g);
         end else push_frame(a, dh, dl, int'($urandom_range(6, 9)));
      end
      budget = 0;
      while (srcq.size() > 0 && budget < 20000) begin
         run_cycle();
         budget++;
      end
      check("rand_drain", 32'(srcq.size()), 32'd0);
      run_n(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cfg_frame_decoder.md
# cfg_frame_decoder

Parses the UART byte stream into configuration-bus write transactions. Sits between the UART-to-system synchronising register (byte + empty flag) and the configuration bus that feeds the clock divider, UART and VGA controller. Decoding and protocol errors are reported as 4-bit codes for the LED manager.

## Interface

- HEADER, 8'hA5, start-of-frame byte.
- TIMEOUT_CYCLES, 100000, maximum idle cycles between bytes inside a frame.
- CNT_W, 17, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- clk  in  1  system clock; the block has one clock.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from the synchronising register.
- rx_empty  in  1  high when no byte is available.
- rx_rd  out  1  one-cycle pop strobe; rx_data is consumed in the same cycle.
- c_valid  out  1  configuration write request.
- c_addr  out  4  configuration register address.
- c_data  out  14  configuration write data.
- c_ready  in  1  AND of all slave readies.
- err_code  out  4  error code, meaningful only while err_valid is high.
- err_valid  out  1  one-cycle error pulse.
- frame_done  out  1  one-cycle pulse when a write completes.
- frame_count  out  8  number of completed writes; wraps from 255 to 0.

## Operation

- Frame format, 5 bytes: HEADER, ADDR, DHI, DLO, CSUM.
- CSUM = ADDR ^ DHI ^ DLO.
- c_addr = ADDR[3:0].
- c_data = {DHI[5:0], DLO}.
- FSM states: IDLE, ADDR, DHI, DLO, CSUM, ISSUE, WAIT_RDY.
- In IDLE, ADDR, DHI, DLO and CSUM, pop whenever rx_empty = 0. rx_rd = ~rx_empty in those states.
- IDLE: a byte equal to HEADER moves to ADDR. Any other byte is discarded silently.
- ADDR: if byte[7:4] != 0, pulse err 4'h1 and return to IDLE. Otherwise latch the byte and go to DHI.
- DHI: if byte[7:6] != 0, pulse err 4'h2 and return to IDLE. Otherwise latch and go to DLO.
- DLO: latch and go to CSUM.
- CSUM: on mismatch, pulse err 4'h3 and return to IDLE. On match, go to ISSUE.
- ISSUE: assert c_valid and drive the latched address and data. Go to WAIT_RDY.
- WAIT_RDY: hold c_valid, c_addr and c_data stable until c_ready = 1 is sampled.
  - On that cycle, pulse frame_done and increment frame_count.
  - c_valid drops the next cycle. Return to IDLE.
- No popping (rx_rd = 0) in ISSUE or WAIT_RDY. Incoming bytes wait in the upstream register (backpressure).
- Timeout counter: clears on every pop and on entry to ADDR, and counts every cycle in ADDR through CSUM.
  - When it reaches TIMEOUT_CYCLES-1 with no byte available, pulse err 4'h4 and return to IDLE.
  - If a byte arrives in the same cycle as the timeout, the byte wins: the block pops it and does not flag an error.
- No timeout applies in WAIT_RDY.
- A HEADER value in a mid-frame position is treated as data, not as a resync.

## Timing

- Reset values:
  - state = IDLE; rx_rd = 0; c_valid = 0.
  - c_addr = 0; c_data = 0.
  - err_code = 0; err_valid = 0.
  - frame_done = 0; frame_count = 0.
- rx_rd is combinational from state and rx_empty. All other outputs are registered.
- err_valid and err_code are asserted in the cycle after the offending pop.
- Latency: c_valid rises exactly 2 cycles after the CSUM pop cycle (CSUM → ISSUE → c_valid registered high).
- With c_ready tied high, c_valid stays high for 2 cycles (ISSUE plus the WAIT_RDY acceptance cycle).
- Back-to-back frames: the next HEADER pop can occur in the first IDLE cycle after WAIT_RDY.
- Asserting rst mid-frame or mid-handshake drops c_valid immediately and discards all partial frame data.

## Structure

- Shared package holds:
  - state encoding;
  - error codes ERR_ADDR = 4'h1, ERR_DATA = 4'h2, ERR_CSUM = 4'h3, ERR_TIMEOUT = 4'h4;
  - default HEADER.
- One sub-module, cfg_timeout_cnt, implements the parameterised clear/enable/expire counter.
- Everything else stays in a single FSM module.

## Test plan

- Stream A5 03 12 34 25, c_ready = 1 → c_valid with c_addr = 4'h3 and c_data = 14'h1234; frame_done pulses once; frame_count = 1.
- Same frame with CSUM = 26 → err_code = 4'h3 with a single err_valid pulse; c_valid never asserted.
- Bytes 00 FF 13, then a valid frame → leading bytes discarded with no error; write issued correctly.
- Frame A5 13 … → err 4'h1 after the ADDR pop. Frame A5 03 52 … → err 4'h2.
- c_ready held low for 5 cycles with the next frame already pending → c_valid and c_data stable for the full wait; rx_rd = 0 throughout; next frame is popped only after acceptance.
- Two timing cases, run with TIMEOUT_CYCLES = 8:
  - A5 03 followed by silence → err 4'h4 after 8 cycles.
  - Separately, rst pulsed low mid-frame → all outputs return to reset values; the next full frame is decoded normally.
